// File: rtl/kdtree_stream_loader.sv
// kdtree_stream_loader
// ---------------------------------------------------------------------------
// Decodes the input-FIFO word stream into the three record types of a k-d
// tree image search and issues one packed write per assembled record:
//   - internal nodes : index word, then median word          (NUM_LEAVES-1)
//   - leaf patches   : PATCH_SIZE element words + image index (NUM_LEAVES*LEAF_SIZE)
//   - query patches  : PATCH_SIZE element words               (NUM_QUERYS)
// A single-cycle load_kdtree starts (or restarts) the sequence. load_done
// tells the main FSM that all data is resident.
//
// Ports
//   clk, rst_n              core clock, asynchronous active-low reset
//   load_kdtree             start/restart command (one cycle)
//   in_fifo_rdata           head word of the first-word-fall-through FIFO
//   in_fifo_rempty_n        FIFO head word valid
//   in_fifo_deq             pop head word (combinational)
//   int_node_*              internal-node write strobe, address, split dim, median
//   leaf_*                  leaf write strobe, leaf number, slot, packed patch, image index
//   query_*                 query write strobe, query number, packed patch
//   busy                    a load is in progress
//   load_done               every record has been written (level)
//   loader_checksum         16-bit wrapping sum of accepted words
//
// Build option
//   LOADER_CHECKSUM_EN      when defined, builds the running word-sum register
//                           behind loader_checksum; otherwise the port is 0.
// ---------------------------------------------------------------------------
module kdtree_stream_loader #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_QUERYS = 494
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_kdtree,
  input  logic [DATA_WIDTH-1:0]            in_fifo_rdata,
  input  logic                             in_fifo_rempty_n,
  output logic                             in_fifo_deq,
  output logic                             int_node_wen,
  output logic [5:0]                       int_node_addr,
  output logic [2:0]                       int_node_idx,
  output logic [DATA_WIDTH-1:0]            int_node_median,
  output logic                             leaf_wen,
  output logic [5:0]                       leaf_addr,
  output logic [2:0]                       leaf_patch_sel,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] leaf_wdata,
  output logic [DATA_WIDTH-1:0]            leaf_patch_idx,
  output logic                             query_wen,
  output logic [8:0]                       query_addr,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0] query_wdata,
  output logic                             busy,
  output logic                             load_done,
  output logic [15:0]                      loader_checksum
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_NODES   = 3'd1,
    ST_LEAVES  = 3'd2,
    ST_QUERIES = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Last value of each record counter, sized to the counter it is compared with.
  localparam logic [5:0] NODE_LAST  = 6'(NUM_LEAVES - 2);
  localparam logic [5:0] LEAF_LAST  = 6'(NUM_LEAVES - 1);
  localparam logic [2:0] SLOT_LAST  = 3'(LEAF_SIZE - 1);
  localparam logic [8:0] QUERY_LAST = 9'(NUM_QUERYS - 1);
  // Element position of the image-index word in a leaf record, and of the
  // final element word of a query record.
  localparam logic [2:0] LEAF_IDX_POS  = 3'(PATCH_SIZE);
  localparam logic [2:0] QUERY_END_POS = 3'(PATCH_SIZE - 1);

  state_t                                   state_r;
  logic                                     busy_r;
  logic                                     load_done_r;

  // Position inside the current record and record-level counters.
  logic [2:0]                               elem_cnt_r;
  logic [5:0]                               node_cnt_r;
  logic [2:0]                               slot_cnt_r;
  logic [5:0]                               leaf_cnt_r;
  logic [8:0]                               query_cnt_r;

  // Assembly registers for the record in flight.
  logic [2:0]                               node_idx_r;
  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0]    patch_buf_r;
  logic [PATCH_SIZE-1:0][DATA_WIDTH-1:0]    query_pack_s;

  // Registered write-port outputs.
  logic                                     int_node_wen_r;
  logic [5:0]                               int_node_addr_r;
  logic [2:0]                               int_node_idx_r;
  logic [DATA_WIDTH-1:0]                    int_node_median_r;
  logic                                     leaf_wen_r;
  logic [5:0]                               leaf_addr_r;
  logic [2:0]                               leaf_patch_sel_r;
  logic [PATCH_SIZE*DATA_WIDTH-1:0]         leaf_wdata_r;
  logic [DATA_WIDTH-1:0]                    leaf_patch_idx_r;
  logic                                     query_wen_r;
  logic [8:0]                               query_addr_r;
  logic [PATCH_SIZE*DATA_WIDTH-1:0]         query_wdata_r;

  logic                                     accept_s;

  // A restart wins over a handshake in the same cycle, so the head word stays
  // in the FIFO and becomes the first word of the new load.
  assign accept_s    = busy_r & in_fifo_rempty_n & ~load_kdtree;
  assign in_fifo_deq = accept_s;

  // The final query element is written straight from the FIFO head so the
  // packed record is available in the same cycle its last word is accepted.
  always_comb begin
    query_pack_s                 = patch_buf_r;
    query_pack_s[PATCH_SIZE-1]   = in_fifo_rdata;
  end

  // Sequencer: phase state, record counters, assembly and registered write ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r           <= ST_IDLE;
      busy_r            <= 1'b0;
      load_done_r       <= 1'b0;
      elem_cnt_r        <= 3'd0;
      node_cnt_r        <= 6'd0;
      slot_cnt_r        <= 3'd0;
      leaf_cnt_r        <= 6'd0;
      query_cnt_r       <= 9'd0;
      node_idx_r        <= 3'd0;
      patch_buf_r       <= '0;
      int_node_wen_r    <= 1'b0;
      int_node_addr_r   <= 6'd0;
      int_node_idx_r    <= 3'd0;
      int_node_median_r <= '0;
      leaf_wen_r        <= 1'b0;
      leaf_addr_r       <= 6'd0;
      leaf_patch_sel_r  <= 3'd0;
      leaf_wdata_r      <= '0;
      leaf_patch_idx_r  <= '0;
      query_wen_r       <= 1'b0;
      query_addr_r      <= 9'd0;
      query_wdata_r     <= '0;
    end else begin
      // Strobes are single-cycle; they are only raised again by a record end.
      int_node_wen_r <= 1'b0;
      leaf_wen_r     <= 1'b0;
      query_wen_r    <= 1'b0;

      if (load_kdtree) begin
        // Restart from any state: the partial record is thrown away.
        state_r     <= ST_NODES;
        busy_r      <= 1'b1;
        load_done_r <= 1'b0;
        elem_cnt_r  <= 3'd0;
        node_cnt_r  <= 6'd0;
        slot_cnt_r  <= 3'd0;
        leaf_cnt_r  <= 6'd0;
        query_cnt_r <= 9'd0;
        node_idx_r  <= 3'd0;
        patch_buf_r <= '0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            busy_r      <= 1'b0;
            load_done_r <= 1'b0;
          end

          ST_NODES: begin
            if (accept_s) begin
              if (elem_cnt_r == 3'd0) begin
                node_idx_r <= in_fifo_rdata[2:0];
                elem_cnt_r <= 3'd1;
              end else begin
                elem_cnt_r        <= 3'd0;
                int_node_wen_r    <= 1'b1;
                int_node_addr_r   <= node_cnt_r;
                int_node_idx_r    <= node_idx_r;
                int_node_median_r <= in_fifo_rdata;
                if (node_cnt_r == NODE_LAST) begin
                  node_cnt_r <= 6'd0;
                  state_r    <= ST_LEAVES;
                end else begin
                  node_cnt_r <= node_cnt_r + 6'd1;
                end
              end
            end
          end

          ST_LEAVES: begin
            if (accept_s) begin
              if (elem_cnt_r == LEAF_IDX_POS) begin
                elem_cnt_r       <= 3'd0;
                leaf_wen_r       <= 1'b1;
                leaf_addr_r      <= leaf_cnt_r;
                leaf_patch_sel_r <= slot_cnt_r;
                leaf_wdata_r     <= patch_buf_r;
                leaf_patch_idx_r <= in_fifo_rdata;
                if (slot_cnt_r == SLOT_LAST) begin
                  slot_cnt_r <= 3'd0;
                  if (leaf_cnt_r == LEAF_LAST) begin
                    leaf_cnt_r <= 6'd0;
                    state_r    <= ST_QUERIES;
                  end else begin
                    leaf_cnt_r <= leaf_cnt_r + 6'd1;
                  end
                end else begin
                  slot_cnt_r <= slot_cnt_r + 3'd1;
                end
              end else begin
                patch_buf_r[elem_cnt_r] <= in_fifo_rdata;
                elem_cnt_r              <= elem_cnt_r + 3'd1;
              end
            end
          end

          ST_QUERIES: begin
            if (accept_s) begin
              if (elem_cnt_r == QUERY_END_POS) begin
                elem_cnt_r    <= 3'd0;
                query_wen_r   <= 1'b1;
                query_addr_r  <= query_cnt_r;
                query_wdata_r <= query_pack_s;
                if (query_cnt_r == QUERY_LAST) begin
                  query_cnt_r <= 9'd0;
                  state_r     <= ST_DONE;
                  // Drop busy with the last word so nothing more is popped.
                  busy_r      <= 1'b0;
                end else begin
                  query_cnt_r <= query_cnt_r + 9'd1;
                end
              end else begin
                patch_buf_r[elem_cnt_r] <= in_fifo_rdata;
                elem_cnt_r              <= elem_cnt_r + 3'd1;
              end
            end
          end

          ST_DONE: begin
            // load_done rises one cycle after the final query strobe.
            busy_r      <= 1'b0;
            load_done_r <= 1'b1;
          end

          default: begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            load_done_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy            = busy_r;
  assign load_done       = load_done_r;
  assign int_node_wen    = int_node_wen_r;
  assign int_node_addr   = int_node_addr_r;
  assign int_node_idx    = int_node_idx_r;
  assign int_node_median = int_node_median_r;
  assign leaf_wen        = leaf_wen_r;
  assign leaf_addr       = leaf_addr_r;
  assign leaf_patch_sel  = leaf_patch_sel_r;
  assign leaf_wdata      = leaf_wdata_r;
  assign leaf_patch_idx  = leaf_patch_idx_r;
  assign query_wen       = query_wen_r;
  assign query_addr      = query_addr_r;
  assign query_wdata     = query_wdata_r;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] checksum_r;

  // Wrapping add of one zero-extended stream word.
  function automatic logic [15:0] checksum_add(input logic [15:0]           sum,
                                               input logic [DATA_WIDTH-1:0] word);
    return sum + 16'(word);
  endfunction

  // Running sum of accepted words; restarts with each load and freezes in DONE
  // because nothing is accepted there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum_r <= 16'd0;
    end else if (load_kdtree) begin
      checksum_r <= 16'd0;
    end else if (accept_s) begin
      checksum_r <= checksum_add(checksum_r, in_fifo_rdata);
    end else begin
      checksum_r <= checksum_r;
    end
  end

  assign loader_checksum = checksum_r;
`else
  assign loader_checksum = 16'd0;
`endif

endmodule

// File: tb/tb_kdtree_stream_loader.sv
// Self-checking bench for kdtree_stream_loader: random stream, reference
// records computed from word positions, gap-free and bubbled loads, restart.
module tb_kdtree_stream_loader;

  localparam int N_NODE_W  = 126;
  localparam int N_LEAF_W  = 3072;
  localparam int N_QUERY_W = 2470;
  localparam int N_WORDS   = N_NODE_W + N_LEAF_W + N_QUERY_W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_kdtree;
  logic [10:0]  in_fifo_rdata;
  logic         in_fifo_rempty_n;
  logic         in_fifo_deq;
  logic         int_node_wen;
  logic [5:0]   int_node_addr;
  logic [2:0]   int_node_idx;
  logic [10:0]  int_node_median;
  logic         leaf_wen;
  logic [5:0]   leaf_addr;
  logic [2:0]   leaf_patch_sel;
  logic [54:0]  leaf_wdata;
  logic [10:0]  leaf_patch_idx;
  logic         query_wen;
  logic [8:0]   query_addr;
  logic [54:0]  query_wdata;
  logic         busy;
  logic         load_done;
  logic [15:0]  loader_checksum;

  kdtree_stream_loader dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .load_kdtree      (load_kdtree),
    .in_fifo_rdata    (in_fifo_rdata),
    .in_fifo_rempty_n (in_fifo_rempty_n),
    .in_fifo_deq      (in_fifo_deq),
    .int_node_wen     (int_node_wen),
    .int_node_addr    (int_node_addr),
    .int_node_idx     (int_node_idx),
    .int_node_median  (int_node_median),
    .leaf_wen         (leaf_wen),
    .leaf_addr        (leaf_addr),
    .leaf_patch_sel   (leaf_patch_sel),
    .leaf_wdata       (leaf_wdata),
    .leaf_patch_idx   (leaf_patch_idx),
    .query_wen        (query_wen),
    .query_addr       (query_addr),
    .query_wdata      (query_wdata),
    .busy             (busy),
    .load_done        (load_done),
    .loader_checksum  (loader_checksum)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  longint      cyc = 0;
  longint      last_q_cyc = 0;
  longint      done_cyc = 0;
  bit          done_seen = 1'b0;

  int unsigned stream_q[$];
  int unsigned fifo_q[$];
  logic [19:0] act_node[$],  exp_node[$];
  logic [74:0] act_leaf[$],  exp_leaf[$];
  logic [63:0] act_query[$], exp_query[$];
  logic [15:0] exp_sum;
  logic [15:0] acc_sum;
  int          acc_cnt;

  // Cycle counter used to time load_done against the final query strobe.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every write strobe seen by the memories, sampled mid-cycle.
  always @(negedge clk) begin
    if (int_node_wen) act_node.push_back({int_node_addr, int_node_idx, int_node_median});
    if (leaf_wen)     act_leaf.push_back({leaf_addr, leaf_patch_sel, leaf_patch_idx, leaf_wdata});
    if (query_wen) begin
      act_query.push_back({query_addr, query_wdata});
      last_q_cyc <= cyc;
    end
    if (load_kdtree)                  done_seen <= 1'b0;
    else if (load_done && !done_seen) begin
      done_seen <= 1'b1;
      done_cyc  <= cyc;
    end
  end

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Random stream with the directed words the first records must show.
  task automatic make_stream();
    stream_q.delete();
    for (int i = 0; i < N_WORDS; i++) stream_q.push_back($urandom_range(0, 2047));
    stream_q[0] = 3; stream_q[1] = 500;
    stream_q[126] = 1; stream_q[127] = 2; stream_q[128] = 3;
    stream_q[129] = 4; stream_q[130] = 5; stream_q[131] = 37;
  endtask

  // Expected records derived purely from each word's position in the stream.
  task automatic build_expected();
    int unsigned sum;
    logic [54:0] d;
    int base;
    exp_node.delete(); exp_leaf.delete(); exp_query.delete();
    for (int n = 0; n < 63; n++)
      exp_node.push_back({6'(n), 3'(stream_q[2*n]), 11'(stream_q[2*n+1])});
    for (int p = 0; p < 512; p++) begin
      base = N_NODE_W + 6*p;
      for (int e = 0; e < 5; e++) d[e*11 +: 11] = 11'(stream_q[base+e]);
      exp_leaf.push_back({6'(p/8), 3'(p%8), 11'(stream_q[base+5]), d});
    end
    for (int q = 0; q < 494; q++) begin
      base = N_NODE_W + N_LEAF_W + 5*q;
      for (int e = 0; e < 5; e++) d[e*11 +: 11] = 11'(stream_q[base+e]);
      exp_query.push_back({9'(q), d});
    end
    sum = 0;
    foreach (stream_q[i]) sum += stream_q[i];
    exp_sum = 16'(sum);
  endtask

  // One-cycle load_kdtree; the FIFO head is presented to prove it is not popped.
  task automatic pulse_load();
    @(negedge clk);
    load_kdtree      = 1'b1;
    in_fifo_rempty_n = (fifo_q.size() > 0);
    in_fifo_rdata    = (fifo_q.size() > 0) ? 11'(fifo_q[0]) : 11'd0;
    #1 chk("deq_during_load", in_fifo_deq, 1'b0);
    @(negedge clk);
    load_kdtree      = 1'b0;
    in_fifo_rempty_n = 1'b0;
  endtask

  // FIFO model: present head word, pop it when the DUT dequeues at the edge.
  task automatic feed(input bit bubbles, input int budget);
    int  cyc_n = 0;
    bit  gate  = 1'b1;
    bit  pop;
    while (fifo_q.size() > 0 && !load_done && cyc_n < budget) begin
      @(negedge clk);
      in_fifo_rempty_n = gate;
      in_fifo_rdata    = 11'(fifo_q[0]);
      #1 pop = in_fifo_deq;
      @(posedge clk);
      if (pop) begin
        acc_sum = acc_sum + 16'(fifo_q[0]);
        acc_cnt++;
        void'(fifo_q.pop_front());
      end
      if (bubbles) gate = !gate;
      cyc_n++;
    end
    chk("feed_within_budget", (cyc_n < budget), 1'b1);
    @(negedge clk);
    in_fifo_rempty_n = (fifo_q.size() > 0);
    in_fifo_rdata    = (fifo_q.size() > 0) ? 11'(fifo_q[0]) : 11'd0;
  endtask

  task automatic full_load(input bit bubbles, input string tag);
    int nb, lb, qb;
    logic [54:0] first_leaf;
    nb = act_node.size(); lb = act_leaf.size(); qb = act_query.size();
    fifo_q = stream_q;
    for (int i = 0; i < 3; i++) fifo_q.push_back($urandom_range(0, 2047));
    acc_sum = 16'd0; acc_cnt = 0;
    pulse_load();
    chk({tag, "_load_done_cleared"}, load_done, 1'b0);
    chk({tag, "_busy_after_load"}, busy, 1'b1);
    feed(bubbles, 30000);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_deq_in_done"}, in_fifo_deq, 1'b0);
    chk({tag, "_load_done"}, load_done, 1'b1);
    chk({tag, "_busy_in_done"}, busy, 1'b0);
    chk({tag, "_extras_left"}, fifo_q.size(), 3);
    chk({tag, "_words_accepted"}, acc_cnt, N_WORDS);
    chk({tag, "_node_count"}, act_node.size() - nb, 63);
    chk({tag, "_leaf_count"}, act_leaf.size() - lb, 512);
    chk({tag, "_query_count"}, act_query.size() - qb, 494);
    for (int i = 0; i < 63 && nb + i < act_node.size(); i++)
      chk($sformatf("%s_node[%0d]", tag, i), act_node[nb+i], exp_node[i]);
    for (int i = 0; i < 512 && lb + i < act_leaf.size(); i++)
      chk($sformatf("%s_leaf[%0d]", tag, i), act_leaf[lb+i], exp_leaf[i]);
    for (int i = 0; i < 494 && qb + i < act_query.size(); i++)
      chk($sformatf("%s_query[%0d]", tag, i), act_query[qb+i], exp_query[i]);
    if (act_node.size() > nb)
      chk({tag, "_first_node"}, act_node[nb], {6'd0, 3'd3, 11'd500});
    first_leaf = {11'd5, 11'd4, 11'd3, 11'd2, 11'd1};
    if (act_leaf.size() > lb)
      chk({tag, "_first_leaf"}, act_leaf[lb], {6'd0, 3'd0, 11'd37, first_leaf});
    if (act_leaf.size() > lb + 511)
      chk({tag, "_last_leaf_addr"}, act_leaf[lb+511][74:66], {6'd63, 3'd7});
    if (act_query.size() > qb + 493)
      chk({tag, "_last_query_addr"}, act_query[qb+493][63:55], 9'd493);
    chk({tag, "_done_timing"}, done_cyc, last_q_cyc + 1);
`ifdef LOADER_CHECKSUM_EN
    chk({tag, "_checksum"}, loader_checksum, exp_sum);
`else
    chk({tag, "_checksum"}, loader_checksum, 16'd0);
`endif
  endtask

  initial begin
    int nb, lb, nb2;
    rst_n            = 1'b0;
    load_kdtree      = 1'b0;
    in_fifo_rdata    = 11'h5a5;
    in_fifo_rempty_n = 1'b1;
    #12;
    chk("reset_ctrl", {in_fifo_deq, int_node_wen, leaf_wen, query_wen, busy, load_done, loader_checksum}, '0);
    chk("reset_data", {int_node_addr, int_node_idx, int_node_median, leaf_addr, leaf_patch_sel,
                       leaf_wdata, leaf_patch_idx, query_addr, query_wdata}, '0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("idle_deq", in_fifo_deq, 1'b0);
    chk("idle_busy", busy, 1'b0);
    in_fifo_rempty_n = 1'b0;

    make_stream();
    build_expected();
    full_load(1'b0, "gapfree");
    full_load(1'b1, "bubbles");

    // Restart after three words of the first leaf patch.
    fifo_q.delete();
    for (int i = 0; i < N_NODE_W + 3; i++) fifo_q.push_back(stream_q[i]);
    pulse_load();
    nb = act_node.size();
    lb = act_leaf.size();
    acc_sum = 16'd0; acc_cnt = 0;
    feed(1'b0, 1000);
    repeat (2) @(negedge clk);
    fifo_q.push_back(2); fifo_q.push_back(77); fifo_q.push_back(9);
    pulse_load();
    chk("restart_nodes_before", act_node.size() - nb, 63);
    chk("restart_no_leaf", act_leaf.size() - lb, 0);
    nb2 = act_node.size();
    acc_sum = 16'd0; acc_cnt = 0;
    feed(1'b0, 100);
    repeat (2) @(negedge clk);
    #1;
    chk("restart_node_count", act_node.size() - nb2, 1);
    if (act_node.size() > nb2)
      chk("restart_first_node", act_node[nb2], {6'd0, 3'd2, 11'd77});
    chk("restart_busy", busy, 1'b1);
    chk("restart_no_leaf_after", act_leaf.size() - lb, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("restart_checksum", loader_checksum, 16'd88);
`else
    chk("restart_checksum", loader_checksum, 16'd0);
`endif

    // Asynchronous reset in the middle of a load clears the sequencer.
    #2 rst_n = 1'b0;
    #1;
    chk("midload_reset", {busy, in_fifo_deq, int_node_wen, leaf_wen, query_wen, load_done}, '0);
    @(negedge clk) rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
